my_ram_n: RTL and testbench
===========================

MY_RAM_N -- requirements
Module: my_ram_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in, input, WIDTH bits: write data.
REQ-006 The block SHALL have port addr, input, ADDR_W bits: read/write address.
REQ-007 The block SHALL have port load, input, 1 bit: write enable.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous request to zero the whole array.
REQ-009 The block SHALL have port out, output, WIDTH bits: read data.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-011 The FSM SHALL have two states: CLEAR and READY.
REQ-012 In CLEAR, each rising edge SHALL write 0 to mem[cnt] and increment cnt; the edge that writes DEPTH-1 SHALL move the FSM to READY and wrap cnt to 0.
REQ-013 A full sweep SHALL take exactly DEPTH rising edges; busy SHALL be 1 in CLEAR and 0 in READY.
REQ-014 In READY, a rising edge with load=1 and clr=0 SHALL write in to mem[addr].
REQ-015 In READY, out SHALL be combinational mem[addr] (zero-cycle read latency); a write becomes visible on out immediately after its edge, and the old value is shown before that edge.
REQ-016 In CLEAR, out SHALL be 0 regardless of addr, and load SHALL be ignored (no write, no queuing).
REQ-017 In READY, clr=1 at a rising edge SHALL enter CLEAR with cnt=0; if load=1 on that same edge, clr SHALL win and the write SHALL be dropped.
REQ-018 clr=1 at an edge while already in CLEAR SHALL restart the sweep (cnt=0 at that edge, no zero written that edge); busy SHALL remain 1.
REQ-019 Address arithmetic SHALL be unsigned ADDR_W bits; cnt SHALL wrap modulo DEPTH with no out-of-range access.
REQ-020 Contents SHALL persist indefinitely in READY while load=0 and clr=0.

Reset
REQ-021 rst=1 SHALL immediately (without a clock edge) force state=CLEAR, cnt=0, busy=1 and out=0.
REQ-022 The memory array SHALL NOT be reset directly; it is zeroed only by the sweep.
REQ-023 While rst=1 no memory write SHALL occur; the sweep SHALL begin on the first rising edge after rst falls.
REQ-024 rst asserted mid-sweep or mid-operation SHALL abort and restart per REQ-021 and REQ-023.

Structure
REQ-025 A shared package my_ram_pkg SHALL hold the state enum type (CLEAR, READY) and the default WIDTH/ADDR_W constants.
REQ-026 The clear sequencer (FSM plus cnt) SHALL be one sub-module, my_ram_clr_seq, with outputs busy, cnt and wr_clr; the array and write mux SHALL live in my_ram_n.
REQ-027 The array SHALL be a single WIDTH x DEPTH register array written from exactly one always block.

Verification
REQ-028 Sweep timing (ADDR_W=4): pulse rst, deassert -> busy=1 for exactly 16 edges, then 0; out=0 throughout; every address then reads 0.
REQ-029 Write/read (defaults): load=1 writes 2@0x000, 9@0x1A7, 1@0xFFF; load=0 -> reads return 2, 9, 1; before the 0x1A7 write edge out shows 0, after it shows 9.
REQ-030 Collision: in READY, apply clr=1 and load=1, in=0x55AA, addr=3 on one edge -> busy=1 next; after the sweep addr 3 reads 0.
REQ-031 Ignored write (ADDR_W=4): during CLEAR, load=1, in=7, addr=15 -> after busy falls addr 15 reads 0.
REQ-032 Async reset: write 0x1234@5, then assert rst between edges -> busy=1 and out=0 with no edge; after the sweep addr 5 reads 0.
REQ-033 Restart: clr=1 at sweep edge 10 (ADDR_W=4) -> busy stays 1 for 16 further edges.

Source files
------------

// File: rtl/my_ram_pkg.sv
// Shared types and default sizing for the self-clearing RAM.
package my_ram_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_ADDR_W = 12;

   // CLEAR sweeps zeros through the array; READY serves normal reads/writes.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

endpackage

// File: rtl/my_ram_clr_seq.sv
// Clear sequencer: walks cnt across every word, asking the array to zero it.
// Any clr request, or reset, restarts the walk from word 0.
module my_ram_clr_seq
   import my_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic [ADDR_W-1:0] cnt,
   output logic              wr_clr
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cnt_nxt;

   // State and sweep pointer register; reset lands in CLEAR at word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: advance the sweep, restart it on clr, leave after the last word.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_clr    = 1'b0;
      case (state)
         CLEAR: begin
            if (clr) begin
               cnt_nxt = '0;
            end else begin
               wr_clr  = !rst;
               cnt_nxt = cnt + ADDR_W'(1);
               if (cnt == LAST) begin
                  state_nxt = READY;
               end
            end
         end
         READY: begin
            if (clr) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy = (state == CLEAR);

endmodule

// File: rtl/my_ram_n.sv
// Single-port RAM with combinational read and a hardware clear sweep.
// The array itself has no reset; it is zeroed word by word by the sequencer.
module my_ram_n
   import my_ram_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] addr,
   input  logic              load,
   input  logic              clr,
   output logic [WIDTH-1:0]  out,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] cnt;
   logic              wr_clr;
   logic              wr_user;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;

   my_ram_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .busy   (busy),
      .cnt    (cnt),
      .wr_clr (wr_clr)
   );

   // Write mux: sweep zeros take the port while busy; user writes lose to clr.
   always_comb begin
      wr_user = !busy && !rst && load && !clr;
      we      = wr_clr || wr_user;
      wr_addr = wr_clr ? cnt : addr;
      wr_data = wr_clr ? '0 : in;
   end

   // The only writer of the array.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read path: contents hidden behind zero while the sweep is running.
   always_comb begin
      out = busy ? '0 : mem[addr];
   end

endmodule

// File: tb/tb_my_ram_n.sv
// Bench for my_ram_n: a 16-word instance for sweep/collision/reset corners
// and a default-sized instance for the wide-address write/read cases.
module tb_my_ram_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small instance (ADDR_W=4)
   logic        sRst, sLoad, sClr, sBusy;
   logic [3:0]  sAddr;
   logic [15:0] sIn, sOut;

   // Default instance (ADDR_W=12)
   logic        bRst, bLoad, bClr, bBusy;
   logic [11:0] bAddr;
   logic [15:0] bIn, bOut;

   int checks = 0;
   int errors = 0;

   // Reference model: contents plus edges remaining in the current sweep
   logic [15:0] sMem [16];
   int          sLeft;
   logic [15:0] bMem [4096];
   int          bLeft;

   typedef struct {
      logic        load;
      logic        clr;
      logic [3:0]  addr;
      logic [15:0] din;
      logic        expBusy;
      logic [15:0] expOut;
   } vec_t;

   vec_t vecs [9];

   my_ram_n #(.WIDTH(16), .ADDR_W(4)) dutSmall (
      .clk (clk), .rst (sRst), .in (sIn), .addr (sAddr),
      .load (sLoad), .clr (sClr), .out (sOut), .busy (sBusy)
   );

   my_ram_n dutBig (
      .clk (clk), .rst (bRst), .in (bIn), .addr (bAddr),
      .load (bLoad), .clr (bClr), .out (bOut), .busy (bBusy)
   );

   // Model: a sweep is "busy for N more edges"; when it finishes everything is zero
   task automatic sModel();
      if (sRst) sLeft = 16;
      else if (sLeft > 0) begin
         if (sClr) sLeft = 16;
         else begin
            sLeft--;
            if (sLeft == 0) foreach (sMem[i]) sMem[i] = '0;
         end
      end else if (sClr) sLeft = 16;
      else if (sLoad) sMem[sAddr] = sIn;
   endtask

   task automatic bModel();
      if (bRst) bLeft = 4096;
      else if (bLeft > 0) begin
         if (bClr) bLeft = 4096;
         else begin
            bLeft--;
            if (bLeft == 0) foreach (bMem[i]) bMem[i] = '0;
         end
      end else if (bClr) bLeft = 4096;
      else if (bLoad) bMem[bAddr] = bIn;
   endtask

   task automatic tick();
      @(posedge clk);
      sModel();
      bModel();
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sCheck(input string name);
      checkOutput({name, " busy"}, 32'(sBusy), 32'(sLeft > 0));
      checkOutput({name, " out"}, 32'(sOut), (sLeft > 0) ? 32'd0 : 32'(sMem[sAddr]));
   endtask

   task automatic bCheck(input string name);
      checkOutput({name, " busy"}, 32'(bBusy), 32'(bLeft > 0));
      checkOutput({name, " out"}, 32'(bOut), (bLeft > 0) ? 32'd0 : 32'(bMem[bAddr]));
   endtask

   task automatic applyStimulus(input logic load, input logic clr, input logic [3:0] addr, input logic [15:0] din);
      sLoad = load;
      sClr  = clr;
      sAddr = addr;
      sIn   = din;
      tick();
   endtask

   task automatic applyBigStimulus(input logic load, input logic clr, input logic [11:0] addr, input logic [15:0] din);
      bLoad = load;
      bClr  = clr;
      bAddr = addr;
      bIn   = din;
      tick();
   endtask

   // Tick with clr low until busy drops; report how many edges it took
   task automatic sWaitIdle(input string name, input int expEdges);
      int n = 0;
      sClr = 1'b0;
      while (sBusy === 1'b1 && n < 64) begin
         tick();
         n++;
         sCheck(name);
      end
      checkOutput({name, " edges"}, 32'(n), 32'(expEdges));
   endtask

   task automatic sReadBack(input string name, input logic [3:0] addr, input logic [15:0] exp);
      sLoad = 1'b0;
      sAddr = addr;
      #1;
      checkOutput(name, 32'(sOut), 32'(exp));
   endtask

   task automatic bReadBack(input string name, input logic [11:0] addr, input logic [15:0] exp);
      bLoad = 1'b0;
      bAddr = addr;
      #1;
      checkOutput(name, 32'(bOut), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      sRst = 1'b1; sLoad = 1'b0; sClr = 1'b0; sAddr = '0; sIn = '0;
      bRst = 1'b1; bLoad = 1'b0; bClr = 1'b0; bAddr = '0; bIn = '0;
      sLeft = 16;
      bLeft = 4096;
      foreach (sMem[i]) sMem[i] = '0;
      foreach (bMem[i]) bMem[i] = '0;

      vecs[0] = '{1'b1, 1'b0, 4'd3,  16'h00AA, 1'b0, 16'h00AA};
      vecs[1] = '{1'b1, 1'b0, 4'd7,  16'h1234, 1'b0, 16'h1234};
      vecs[2] = '{1'b0, 1'b0, 4'd3,  16'hFFFF, 1'b0, 16'h00AA};
      vecs[3] = '{1'b0, 1'b0, 4'd7,  16'h0000, 1'b0, 16'h1234};
      vecs[4] = '{1'b1, 1'b0, 4'd3,  16'hBEEF, 1'b0, 16'hBEEF};
      vecs[5] = '{1'b0, 1'b0, 4'd15, 16'h0001, 1'b0, 16'h0000};
      vecs[6] = '{1'b1, 1'b0, 4'd15, 16'hFFFF, 1'b0, 16'hFFFF};
      vecs[7] = '{1'b0, 1'b0, 4'd3,  16'h0000, 1'b0, 16'hBEEF};
      vecs[8] = '{1'b1, 1'b1, 4'd3,  16'h55AA, 1'b1, 16'h0000};

      // Reset state
      tick();
      tick();
      sCheck("reset small");
      bCheck("reset big");

      // Initial sweep after reset release: 16 busy edges, out held at zero
      sRst = 1'b0;
      bRst = 1'b0;
      sWaitIdle("initial sweep", 16);
      for (int i = 0; i < 16; i++) sReadBack($sformatf("swept addr %0d", i), 4'(i), 16'h0000);

      // Table of writes/reads ending in a clr+load collision
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].load, vecs[i].clr, vecs[i].addr, vecs[i].din);
         checkOutput($sformatf("vec%0d busy", i), 32'(sBusy), 32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d out", i), 32'(sOut), 32'(vecs[i].expOut));
         sCheck($sformatf("vec%0d model", i));
      end

      // Writes attempted mid-sweep must be ignored
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd15, 16'h0007);
         sCheck("ignored write");
      end
      sLoad = 1'b0;
      sWaitIdle("collision sweep", 11);
      sReadBack("collision addr3", 4'd3, 16'h0000);
      sReadBack("ignored addr15", 4'd15, 16'h0000);
      sReadBack("cleared addr7", 4'd7, 16'h0000);

      // Restart: clr on sweep edge 10 gives 16 further busy edges
      #2;
      sRst = 1'b1;
      sLeft = 16;
      #1;
      sCheck("restart rst");
      tick();
      sRst = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b0, 1'b0, 4'(i), 16'h0000);
         sCheck("restart pre");
      end
      applyStimulus(1'b0, 1'b1, 4'd0, 16'h0000);
      sCheck("restart clr edge");
      sWaitIdle("restart sweep", 16);

      // Asynchronous reset between edges
      applyStimulus(1'b1, 1'b0, 4'd5, 16'h1234);
      checkOutput("write 0x1234 at 5", 32'(sOut), 32'h1234);
      sLoad = 1'b0;
      #2;
      sRst = 1'b1;
      sLeft = 16;
      #1;
      checkOutput("async rst busy", 32'(sBusy), 32'd1);
      checkOutput("async rst out", 32'(sOut), 32'd0);
      tick();
      sRst = 1'b0;
      sWaitIdle("post rst sweep", 16);
      sReadBack("rst cleared addr5", 4'd5, 16'h0000);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
                       4'($urandom_range(0, 15)), 16'($urandom));
         sCheck("rand small");
      end
      sLoad = 1'b0;
      sClr  = 1'b0;

      // Default-sized instance: finish its initial sweep
      n = 0;
      while (bLeft > 0 && n < 5000) begin
         tick();
         n++;
      end
      checkOutput("big sweep done", 32'(bBusy), 32'd0);
      bReadBack("big swept 0x1A7", 12'h1A7, 16'h0000);

      // Wide-address writes, with old value visible just before the edge
      applyBigStimulus(1'b1, 1'b0, 12'h000, 16'd2);
      bCheck("big write 0");
      bLoad = 1'b1;
      bAddr = 12'h1A7;
      bIn   = 16'd9;
      #1;
      checkOutput("big 0x1A7 before edge", 32'(bOut), 32'd0);
      tick();
      checkOutput("big 0x1A7 after edge", 32'(bOut), 32'd9);
      applyBigStimulus(1'b1, 1'b0, 12'hFFF, 16'd1);
      bCheck("big write FFF");
      bReadBack("big read 0x000", 12'h000, 16'd2);
      bReadBack("big read 0x1A7", 12'h1A7, 16'd9);
      bReadBack("big read 0xFFF", 12'hFFF, 16'd1);

      // Randomized traffic on the default instance, then a persistence check
      for (int i = 0; i < 200; i++) begin
         applyBigStimulus(1'($urandom_range(0, 1)), 1'b0, 12'($urandom_range(0, 4095)), 16'($urandom));
         bCheck("rand big");
      end
      for (int i = 0; i < 20; i++) begin
         applyBigStimulus(1'b0, 1'b0, 12'($urandom_range(0, 4095)), 16'($urandom));
         bCheck("persist big");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
